// File: rtl/intt_input_packer.sv
// Packs serial coefficients into PE_NUM-lane words for the INTT operand BRAM,
// then kicks off the INTT and waits for its completion. Define INTT_PACKER_MODRED_EN
// to fold each input from [0,2Q) into [0,Q) before it is stored.
module intt_input_packer #(
  parameter int                DATA_W = 27,
  parameter int                PE_NUM = 8,
  parameter int                RING_N = 1024,
  parameter logic [DATA_W-1:0] Q      = 27'h7FE0001,
  localparam int               WORDS  = RING_N / PE_NUM,
  localparam int               ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     load_bram,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [DATA_W*PE_NUM-1:0] bramIn,
  output logic                     start_intt,
  input  logic                     done_intt,
  output logic                     busy
);

  localparam int LANE_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

  if ((RING_N % PE_NUM) != 0 || Q == '0) begin : g_bad_cfg
    $error("intt_input_packer: RING_N must be a multiple of PE_NUM and Q nonzero");
  end

  typedef enum logic [1:0] {
    S_FILL,
    S_WRITE,
    S_START,
    S_WAIT
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [LANE_W-1:0]          r_lane;
  logic [ADDR_W-1:0]          r_word;
  logic [DATA_W-1:0]          r_lane_data [PE_NUM];
  logic [DATA_W*PE_NUM-1:0]   r_bram_in;
  logic [ADDR_W-1:0]          r_bram_addr;
  logic [DATA_W*PE_NUM-1:0]   w_word;
  logic [DATA_W-1:0]          w_coef;
  logic                       w_accept;
  logic                       w_last_lane;
  logic                       w_last_word;

  assign s_ready     = (r_state == S_FILL) && !reset;
  assign w_accept    = s_valid && s_ready;
  assign w_last_lane = (r_lane == LANE_W'(PE_NUM - 1));
  assign w_last_word = (r_word == ADDR_W'(WORDS - 1));

`ifdef INTT_PACKER_MODRED_EN
  assign w_coef = (s_data >= Q) ? (s_data - Q) : s_data;
`else
  assign w_coef = s_data;
`endif

  // The word handed to the BRAM register merges the incoming coefficient into
  // its lane, so the write can happen the cycle right after the final accept.
  for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (reset) begin
        r_lane_data[gi] <= '0;
      end else if (w_accept && (r_lane == LANE_W'(gi))) begin
        r_lane_data[gi] <= w_coef;
      end
    end

    assign w_word[DATA_W*gi +: DATA_W] = (r_lane == LANE_W'(gi)) ? w_coef : r_lane_data[gi];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:  if (w_accept && w_last_lane) w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last_word ? S_START : S_FILL;
      S_START: w_state_next = S_WAIT;
      S_WAIT:  if (done_intt) w_state_next = S_FILL;
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_lane      <= '0;
      r_word      <= '0;
      r_bram_in   <= '0;
      r_bram_addr <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_lane <= w_last_lane ? '0 : r_lane + LANE_W'(1);
      end

      if (w_accept && w_last_lane) begin
        r_bram_in   <= w_word;
        r_bram_addr <= r_word;
      end

      if (r_state == S_WRITE) begin
        r_word <= w_last_word ? '0 : r_word + ADDR_W'(1);
      end

      if (r_state == S_WAIT && done_intt) begin
        r_lane <= '0;
        r_word <= '0;
      end
    end
  end

  assign load_bram  = (r_state == S_WRITE);
  assign start_intt = (r_state == S_START);
  assign busy       = (r_state != S_FILL);
  assign bramIn     = r_bram_in;
  assign bram_addr  = r_bram_addr;

endmodule

// File: doc/intt_input_packer.md
INTT_INPUT_PACKER -- requirements
Module: intt_input_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 27, the coefficient width (matches `DATA_SIZE_ARB).
REQ-002 SHALL have parameter PE_NUM, default 8, the lanes per packed word (matches `PE_NUMBER).
REQ-003 SHALL have parameter RING_N, default 1024, the coefficients per polynomial, a multiple of PE_NUM.
REQ-004 SHALL have parameter Q, default 27'h7FE0001, the modulus.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 SHALL have port s_data, input, DATA_W, the serial coefficient.
REQ-008 SHALL have port s_valid, input, 1, marking s_data as valid.
REQ-009 SHALL have port s_ready, output, 1; a coefficient is accepted when s_valid&&s_ready.
REQ-010 SHALL have port load_bram, output, 1, the one-cycle write strobe for bramIn.
REQ-011 SHALL have port bram_addr, output, log2(RING_N/PE_NUM), the packed word address.
REQ-012 SHALL have port bramIn, output, DATA_W*PE_NUM, the packed word.
REQ-013 SHALL have port start_intt, output, 1, a one-cycle INTT start pulse.
REQ-014 SHALL have port done_intt, input, 1, the INTT completion indication.
REQ-015 SHALL have port busy, output, 1, high in every state except FILL.

Function
REQ-016 SHALL implement FSM states FILL, WRITE, START and WAIT; reset enters FILL.
REQ-017 FILL: s_ready=1; each accept stores the coefficient in lane k mod PE_NUM at bits [DATA_W*lane +: DATA_W] and increments the lane counter.
REQ-018 Accept at lane PE_NUM-1 SHALL move the FSM to WRITE.
REQ-019 WRITE SHALL last exactly one cycle: load_bram=1, bramIn=the packed word, bram_addr=word counter.
REQ-020 WRITE SHALL then increment the word counter, then return to FILL, or go to START if the word written was RING_N/PE_NUM-1.
REQ-021 s_ready SHALL be 0 in WRITE, START and WAIT (one-cycle bubble per word).
REQ-022 START SHALL last one cycle with start_intt=1, then go to WAIT.
REQ-023 WAIT SHALL hold until done_intt=1 is sampled, then return to FILL with the lane and word counters at 0.
REQ-024 done_intt SHALL be ignored in every state except WAIT, including the START cycle.
REQ-025 Latency: the last coefficient accepted in cycle t gives load_bram at t+1 and start_intt at t+2.
REQ-026 Counters SHALL wrap to 0 after a polynomial completes, never saturate; lanes not yet written this word hold their previous value.
REQ-027 bramIn and bram_addr SHALL be registered, and held stable outside WRITE.
REQ-028 s_data SHALL be ignored when s_valid=0; s_valid may drop mid-word without corrupting the lane count.

Reset
REQ-029 On reset=1 at a clock edge: state=FILL, lane=0, word=0, load_bram=0, start_intt=0, bramIn=0, bram_addr=0, busy=0.
REQ-030 s_ready SHALL be 0 in any cycle where reset=1.
REQ-031 Reset mid-polynomial, or in WAIT, SHALL discard the partial word and counts; the next accepted coefficient is k=0.

Configuration
REQ-032 Macro INTT_PACKER_MODRED_EN SHALL select input reduction; with it defined, each accepted s_data in [0,2Q) is stored as s_data-Q if s_data>=Q, else unchanged.
REQ-033 Input reduction SHALL be combinational ahead of the lane register, with no added latency.
REQ-034 Without INTT_PACKER_MODRED_EN, s_data SHALL be stored unmodified and the subtractor SHALL be absent.

Verification
REQ-035 Reset, then s_valid=1 continuously with data=k for k=0..1023 -> 128 load_bram pulses; word a lane j = 8a+j; addresses 0..127 in order; one start_intt two cycles after the last accept; busy=1 afterwards.
REQ-036 In WAIT, hold s_valid=1 for 50 cycles, then pulse done_intt -> s_ready=0 throughout; FILL re-entered the next cycle; next coefficient lands at addr 0, lane 0.
REQ-037 Drive done_intt=1 during FILL and during the START cycle -> no state change and no extra start_intt.
REQ-038 Assert reset after 13 accepts, then stream 8 coefficients -> first load_bram at addr 0 containing only post-reset data.
REQ-039 Random s_valid gaps (~50% duty) -> packing identical to the gap-free case.
REQ-040 With INTT_PACKER_MODRED_EN defined, input Q+5, Q-1, 0 -> stored 5, Q-1, 0; without the macro, Q+5 is stored as Q+5.
